// File: rtl/fp32_pkg.sv
// Shared FP32 field definitions and the four-way class encoding used by the
// multiplier datapath and its result buffer.
package fp32_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

  typedef enum logic [1:0] {
    FP_NORM = 2'b00,
    FP_ZERO = 2'b01,
    FP_INF  = 2'b10,
    FP_NAN  = 2'b11
  } fp_class_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 classifier: NaN, infinity, zero, or finite nonzero
// (denormals count as finite nonzero). Sign does not affect the class.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] data,
  output fp_class_t   cls
);

  logic [31:0]       mag;
  logic [EXP_W-1:0]  exp_bits;
  logic [FRAC_W-1:0] frac_bits;

  // Sign is masked off so +0/-0 and +inf/-inf classify identically.
  assign mag       = data & 32'h7FFF_FFFF;
  assign exp_bits  = mag[30:23];
  assign frac_bits = mag[22:0];

  always_comb begin
    cls = FP_NORM;
    if (exp_bits == EXP_MAX) begin
      cls = (frac_bits != '0) ? FP_NAN : FP_INF;
    end else if (mag == '0) begin
      cls = FP_ZERO;
    end
  end

endmodule

// File: rtl/fp_mul_result_buffer.sv
// Result buffer behind the FP32 multiplier: classifies each accepted product,
// queues product+class in a circular FIFO, and keeps sticky flags and counters.
module fp_mul_result_buffer
  import fp32_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [1:0]         out_class,
  input  logic               clr_stats,
  output logic               flag_nan,
  output logic               flag_inf,
  output logic               flag_zero,
  output logic [COUNT_W-1:0] cnt_nan,
  output logic [COUNT_W-1:0] cnt_inf,
  output logic [COUNT_W-1:0] cnt_zero,
  output logic [COUNT_W-1:0] cnt_norm
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_OCC = (PTR_W+1)'(DEPTH);
  localparam logic [COUNT_W-1:0] ONE    = COUNT_W'(1);

  logic [31:0]    mem_data  [DEPTH];
  fp_class_t      mem_class [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;

  fp_class_t push_class;
  logic      push;
  logic      pop;

  fp32_classify u_classify (
    .data (in_data),
    .cls  (push_class)
  );

  // in_ready comes only from registered occupancy, never from out_ready.
  assign in_ready  = (occ != FULL_OCC);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = out_valid ? mem_data[rd_ptr] : 32'h0;
  assign out_class = out_valid ? mem_class[rd_ptr] : FP_NORM;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_data[wr_ptr]  <= in_data;
      mem_class[wr_ptr] <= push_class;
    end
  end

  // A same-cycle push after clr_stats is counted from zero, so the later
  // assignment below wins for the pushed class.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_nan  <= 1'b0;
      flag_inf  <= 1'b0;
      flag_zero <= 1'b0;
      cnt_nan   <= '0;
      cnt_inf   <= '0;
      cnt_zero  <= '0;
      cnt_norm  <= '0;
    end else begin
      if (clr_stats) begin
        flag_nan  <= 1'b0;
        flag_inf  <= 1'b0;
        flag_zero <= 1'b0;
        cnt_nan   <= '0;
        cnt_inf   <= '0;
        cnt_zero  <= '0;
        cnt_norm  <= '0;
      end
      if (push) begin
        case (push_class)
          FP_NAN: begin
            flag_nan <= 1'b1;
            cnt_nan  <= clr_stats ? ONE : sat_inc(cnt_nan);
          end
          FP_INF: begin
            flag_inf <= 1'b1;
            cnt_inf  <= clr_stats ? ONE : sat_inc(cnt_inf);
          end
          FP_ZERO: begin
            flag_zero <= 1'b1;
            cnt_zero  <= clr_stats ? ONE : sat_inc(cnt_zero);
          end
          default: begin
            cnt_norm <= clr_stats ? ONE : sat_inc(cnt_norm);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_result_buffer.sv
// Bench for fp_mul_result_buffer: two instances (16-bit and 4-bit counters)
// share stimulus and are compared against a queue-based reference model.
module tb_fp_mul_result_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_stats = 1'b0;
  logic [31:0] in_data = 32'h0;

  logic        in_ready, out_valid, flag_nan, flag_inf, flag_zero;
  logic [31:0] out_data;
  logic [1:0]  out_class;
  logic [15:0] cnt_nan, cnt_inf, cnt_zero, cnt_norm;

  logic        in_ready_s, out_valid_s, flag_nan_s, flag_inf_s, flag_zero_s;
  logic [31:0] out_data_s;
  logic [1:0]  out_class_s;
  logic [3:0]  cnt_nan_s, cnt_inf_s, cnt_zero_s, cnt_norm_s;

  always #5 clk = ~clk;

  fp_mul_result_buffer #(.DEPTH(DEPTH), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_class(out_class),
    .clr_stats(clr_stats), .flag_nan(flag_nan), .flag_inf(flag_inf), .flag_zero(flag_zero),
    .cnt_nan(cnt_nan), .cnt_inf(cnt_inf), .cnt_zero(cnt_zero), .cnt_norm(cnt_norm)
  );

  fp_mul_result_buffer #(.DEPTH(DEPTH), .COUNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_class(out_class_s),
    .clr_stats(clr_stats), .flag_nan(flag_nan_s), .flag_inf(flag_inf_s), .flag_zero(flag_zero_s),
    .cnt_nan(cnt_nan_s), .cnt_inf(cnt_inf_s), .cnt_zero(cnt_zero_s), .cnt_norm(cnt_norm_s)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: class index 0 norm, 1 zero, 2 inf, 3 nan.
  logic [31:0] q_data[$];
  logic [1:0]  q_cls[$];
  int          cnt_big[4];
  int          cnt_small[4];
  bit          flg[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_class(input logic [31:0] x);
    int e, f;
    e = int'((x >> 23) & 32'hFF);
    f = int'(x & 32'h7FFFFF);
    if (e == 255) return (f != 0) ? 2'd3 : 2'd2;
    if (e == 0 && f == 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic int sat_add(input int v, input int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic check_all();
    logic [31:0] exp_d;
    logic [1:0]  exp_c;
    bit          exp_v;
    exp_v = (q_data.size() > 0);
    exp_d = exp_v ? q_data[0] : 32'h0;
    exp_c = exp_v ? q_cls[0] : 2'd0;
    check_eq("in_ready",   {31'h0, in_ready},    {31'h0, q_data.size() < DEPTH});
    check_eq("out_valid",  {31'h0, out_valid},   {31'h0, exp_v});
    check_eq("out_data",   out_data,             exp_d);
    check_eq("out_class",  {30'h0, out_class},   {30'h0, exp_c});
    check_eq("flag_nan",   {31'h0, flag_nan},    {31'h0, flg[3]});
    check_eq("flag_inf",   {31'h0, flag_inf},    {31'h0, flg[2]});
    check_eq("flag_zero",  {31'h0, flag_zero},   {31'h0, flg[1]});
    check_eq("cnt_norm",   {16'h0, cnt_norm},    cnt_big[0]);
    check_eq("cnt_zero",   {16'h0, cnt_zero},    cnt_big[1]);
    check_eq("cnt_inf",    {16'h0, cnt_inf},     cnt_big[2]);
    check_eq("cnt_nan",    {16'h0, cnt_nan},     cnt_big[3]);
    check_eq("s_in_ready", {31'h0, in_ready_s},  {31'h0, q_data.size() < DEPTH});
    check_eq("s_out_valid",{31'h0, out_valid_s}, {31'h0, exp_v});
    check_eq("s_out_data", out_data_s,           exp_d);
    check_eq("s_out_class",{30'h0, out_class_s}, {30'h0, exp_c});
    check_eq("s_flag_nan", {31'h0, flag_nan_s},  {31'h0, flg[3]});
    check_eq("s_flag_inf", {31'h0, flag_inf_s},  {31'h0, flg[2]});
    check_eq("s_flag_zero",{31'h0, flag_zero_s}, {31'h0, flg[1]});
    check_eq("s_cnt_norm", {28'h0, cnt_norm_s},  cnt_small[0]);
    check_eq("s_cnt_zero", {28'h0, cnt_zero_s},  cnt_small[1]);
    check_eq("s_cnt_inf",  {28'h0, cnt_inf_s},   cnt_small[2]);
    check_eq("s_cnt_nan",  {28'h0, cnt_nan_s},   cnt_small[3]);
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic tick(input logic r, input logic v, input logic [31:0] d,
                      input logic rdy, input logic clr);
    bit push, pop;
    logic [1:0] c;
    rst = r; in_valid = v; in_data = d; out_ready = rdy; clr_stats = clr;
    push = !r && v && (q_data.size() < DEPTH);
    pop  = !r && rdy && (q_data.size() > 0);
    @(posedge clk);
    if (r) begin
      q_data.delete();
      q_cls.delete();
      for (int i = 0; i < 4; i++) begin
        cnt_big[i] = 0; cnt_small[i] = 0; flg[i] = 0;
      end
    end else begin
      if (pop) begin
        void'(q_data.pop_front());
        void'(q_cls.pop_front());
      end
      if (clr) begin
        for (int i = 0; i < 4; i++) begin
          cnt_big[i] = 0; cnt_small[i] = 0; flg[i] = 0;
        end
      end
      if (push) begin
        c = ref_class(d);
        q_data.push_back(d);
        q_cls.push_back(c);
        if (c != 2'd0) flg[c] = 1;
        cnt_big[c]   = sat_add(cnt_big[c], 65535);
        cnt_small[c] = sat_add(cnt_small[c], 15);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rand_operand();
    logic        s;
    logic [22:0] f;
    logic [7:0]  e;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom_range(1, 32'h7FFFFF));
    e = 8'($urandom_range(1, 254));
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return {s, 31'h0};
      2:       return {s, 8'hFF, 23'h0};
      3:       return {s, 8'hFF, f};
      4:       return {s, 8'h00, f};
      default: return {s, e, f};
    endcase
  endfunction

  initial begin
    tick(1, 0, 32'h0, 0, 0);
    tick(1, 1, 32'h3F800000, 1, 1);

    // Single normal push, no bypass, then pop it.
    tick(0, 1, 32'h3F800000, 0, 0);
    tick(0, 0, 32'h0, 1, 0);

    // Three specials held, then drained in order.
    tick(0, 1, 32'h7FC00000, 0, 0);
    tick(0, 1, 32'h7F800000, 0, 0);
    tick(0, 1, 32'h80000000, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 32'h0, 1, 0);

    // Fill, hold the fifth value upstream, accept it only after a pop.
    for (int i = 0; i < DEPTH; i++) tick(0, 1, 32'h40000000 + 32'(i), 0, 0);
    tick(0, 1, 32'h40A00000, 0, 0);
    tick(0, 1, 32'h40A00000, 0, 0);
    tick(0, 1, 32'h40A00000, 1, 0);
    tick(0, 1, 32'h40A00000, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) tick(0, 0, 32'h0, 1, 0);

    // Sustained push+pop at occupancy 1 across pointer wrap.
    tick(0, 1, 32'h41000000, 0, 0);
    for (int i = 0; i < 100; i++) tick(0, 1, 32'h41000001 + 32'(i), 1, 0);
    tick(0, 0, 32'h0, 1, 0);

    // Zero-count saturation on the 4-bit instance, then clear with a NaN push.
    for (int i = 0; i < 20; i++) tick(0, 1, 32'h00000000, 1, 0);
    tick(0, 1, 32'h7FC00000, 1, 1);
    tick(0, 0, 32'h0, 1, 0);

    // Reset with entries queued discards them.
    for (int i = 0; i < 3; i++) tick(0, 1, 32'hC0400000 + 32'(i), 0, 0);
    tick(1, 1, 32'h7F800000, 1, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 32'h0, 1, 0);

    for (int i = 0; i < 2000; i++) begin
      tick(1'($urandom_range(0, 199) == 0),
           1'($urandom_range(0, 3) != 0),
           rand_operand(),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_result_buffer.md
# fp_mul_result_buffer

Output stage placed directly downstream of the combinational FP32 multiplier. It accepts each product over a valid/ready handshake, classifies it (normal, zero, infinity, NaN), and queues it with its class in a small FIFO toward the consumer. It also keeps sticky exception flags and saturating per-class event counters for software and debug visibility.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- COUNT_W, 16, width of each per-class counter.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  product on in_data is valid.
- in_ready  out  1  buffer can accept; equals not-full.
- in_data  in  32  IEEE-754 single product from the multiplier.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  32  head product; 0 when empty.
- out_class  out  2  head class: 00 finite nonzero, 01 zero, 10 infinity, 11 NaN; 00 when empty.
- clr_stats  in  1  clears sticky flags and counters.
- flag_nan, flag_inf, flag_zero  out  1 each  sticky, set by any accepted product of that class.
- cnt_nan, cnt_inf, cnt_zero, cnt_norm  out  COUNT_W each  accepted-product counts, saturating.

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Classification of in_data at push: exp 8'hFF with frac nonzero -> NaN; exp 8'hFF with frac zero -> inf; exp 0 with frac 0 -> zero; all else, including denormals -> finite nonzero. Sign is ignored for class.
- FIFO storage is circular: read and write pointers are log2(DEPTH) bits and wrap naturally. Occupancy counter is log2(DEPTH)+1 bits.
- Full when occupancy == DEPTH. Empty when occupancy == 0.
- Push when full is impossible, because in_ready is 0. in_valid while full is held upstream; there is no drop.
- Pop when empty is impossible, because out_valid is 0.
- Simultaneous push and pop with occupancy between 1 and DEPTH-1: occupancy unchanged, both pointers advance.
- Simultaneous push and pop when full: not possible, since in_ready is 0 at the start of the cycle. in_ready does not depend combinationally on out_ready.
- No bypass: a product pushed into an empty FIFO appears at out_* one cycle later.
- Counters increment by 1 per accepted product of their class and hold at all-ones (2^COUNT_W - 1).
- clr_stats zeroes all flags and counters. If a push occurs in the same cycle, the clear applies first and that product's class is then counted. The result is flag 1, count 1 for the pushed class and 0 for the others.
- clr_stats does not affect FIFO contents or pointers.

## Timing
- Reset values (after rst high at a clock edge):
  - pointers and occupancy 0
  - in_ready 1, out_valid 0, out_data 0, out_class 00
  - all flags 0, all counters 0
- Reset mid-operation discards all queued entries and statistics in that cycle. Inputs are ignored while rst is high.
- Latency: push at edge N makes the entry visible at out_* after edge N, when it is at the head.
- Throughput: one push and one pop per cycle sustained.
- Flags and counters update at the push edge and are registered outputs.
- out_data and out_class stay stable while out_valid && !out_ready.

## Structure
- Shared package fp32_pkg holds:
  - field widths: SIGN 1, EXP 8, FRAC 23
  - EXP_MAX 8'hFF
  - QNAN 32'h7FC00000
  - the class enum fp_class_t (FP_NORM, FP_ZERO, FP_INF, FP_NAN, encoded as above)
- Sub-module fp32_classify, combinational: 32-bit in, fp_class_t out. It is reusable by the multiplier's special-case logic.
- The FIFO storage array, the pointers and the statistics registers live in fp_mul_result_buffer itself.

## Test plan
- Reset, then push 32'h3F800000 (1.0) -> next cycle out_valid 1, out_data 32'h3F800000, out_class 00, cnt_norm 1, all flags 0.
- Push 32'h7FC00000, 32'h7F800000, 32'h80000000 with out_ready 0 -> flag_nan, flag_inf and flag_zero all 1, one count each. Then release out_ready -> the three products drain in order with classes 11, 10, 01.
- Hold out_ready 0 and push DEPTH items -> in_ready drops to 0 after the 4th push, the 5th value stays held upstream, and the FIFO accepts it only after a pop.
- Full stream of 100 alternating pushes and pops with occupancy 1 -> occupancy stays 1, data order is preserved across pointer wrap, and there is no bubble.
- COUNT_W forced to 4: push 20 zeros -> cnt_zero saturates at 15. Then clr_stats with a simultaneous NaN push -> cnt_zero 0, cnt_nan 1, flag_nan 1.
- Assert rst with 3 entries queued -> next cycle out_valid 0, in_ready 1, counters 0, and previous data never appears at out_data.
